// File: rtl/spirxdata.sv
// SD-card SPI data-block receiver: hunts for the 0xFE start token, packs bytes into words for block memory, checks CRC16.
// Optional feature macro: SPIRXDATA_CRC_EN builds the CRC16 register and comparator.
module spirxdata #(
  parameter int DW        = 32,
  parameter int AW        = 8,
  parameter int LGTIMEOUT = 10
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  input  logic [3:0]    i_lgblksz,
  input  logic          i_fifo,
  output logic          o_busy,
  output logic          o_write,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_data,
  input  logic          i_ll_busy,
  output logic          o_ll_stb,
  output logic [7:0]    o_ll_byte,
  input  logic          i_ll_stb,
  input  logic [7:0]    i_ll_byte,
  output logic          o_done,
  output logic          o_err,
  output logic          o_crc_err,
  output logic          o_timeout
);

  // IDLE wait start | TOKEN hunt 0xFE | DATA pack words | CRC read 2 bytes | DONE drain driver
  typedef enum logic [2:0] {S_IDLE, S_TOKEN, S_DATA, S_CRC, S_DONE} state_t;

  state_t               r_state;
  logic [3:0]           r_lgblksz;
  logic [9:0]           r_cnt;
  logic [LGTIMEOUT-1:0] r_tmo;
  logic [DW-9:0]        r_word;
  logic                 r_crcb;
  logic [3:0]           w_lg;
  logic [9:0]           w_last;

  assign o_ll_byte = 8'hff;
  assign w_lg      = (i_lgblksz < 4'd4) ? 4'd4 : ((i_lgblksz > 4'd9) ? 4'd9 : i_lgblksz);
  assign w_last    = (10'd1 << r_lgblksz) - 10'd1;

`ifdef SPIRXDATA_CRC_EN
  logic [15:0] r_crc;
  logic [7:0]  r_crc_hi;

  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] x;
    x = c;
    for (int i = 7; i >= 0; i--)
      x = {x[14:0], 1'b0} ^ (((x[15] ^ b[i]) != 1'b0) ? 16'h1021 : 16'h0000);
    return x;
  endfunction
`else
  assign o_crc_err = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_lgblksz <= 4'd4;
      r_cnt     <= '0;
      r_tmo     <= '0;
      r_word    <= '0;
      r_crcb    <= 1'b0;
      o_busy    <= 1'b0;
      o_write   <= 1'b0;
      o_addr    <= '0;
      o_data    <= '0;
      o_ll_stb  <= 1'b0;
      o_done    <= 1'b0;
      o_err     <= 1'b0;
      o_timeout <= 1'b0;
`ifdef SPIRXDATA_CRC_EN
      r_crc     <= '0;
      r_crc_hi  <= '0;
      o_crc_err <= 1'b0;
`endif
    end else begin
      o_write <= 1'b0;
      o_done  <= 1'b0;
      if (o_write)
        o_addr[AW-2:0] <= o_addr[AW-2:0] + 1'b1;

      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state   <= S_TOKEN;
            r_lgblksz <= w_lg;
            r_cnt     <= '0;
            r_tmo     <= '0;
            r_crcb    <= 1'b0;
            o_addr    <= {i_fifo, {(AW-1){1'b0}}};
            o_busy    <= 1'b1;
            o_ll_stb  <= 1'b1;
            o_err     <= 1'b0;
            o_timeout <= 1'b0;
`ifdef SPIRXDATA_CRC_EN
            r_crc     <= '0;
            o_crc_err <= 1'b0;
`endif
          end
        end

        S_TOKEN: begin
          if (i_ll_stb) begin
            if (i_ll_byte == 8'hfe) begin
              r_state <= S_DATA;
            end else if (i_ll_byte[7:4] == 4'h0) begin
              o_err    <= 1'b1;
              o_ll_stb <= 1'b0;
              r_state  <= S_DONE;
            end else if (r_tmo == {LGTIMEOUT{1'b1}}) begin
              o_timeout <= 1'b1;
              o_ll_stb  <= 1'b0;
              r_state   <= S_DONE;
            end else begin
              r_tmo <= r_tmo + 1'b1;
            end
          end
        end

        S_DATA: begin
          if (i_ll_stb) begin
            r_word <= {r_word[DW-17:0], i_ll_byte};
            r_cnt  <= r_cnt + 1'b1;
`ifdef SPIRXDATA_CRC_EN
            r_crc  <= crc16_byte(r_crc, i_ll_byte);
`endif
            if (r_cnt[1:0] == 2'b11) begin
              o_write <= 1'b1;
              o_data  <= {r_word, i_ll_byte};
            end
            if (r_cnt == w_last)
              r_state <= S_CRC;
          end
        end

        S_CRC: begin
          if (i_ll_stb) begin
            r_crcb <= 1'b1;
`ifdef SPIRXDATA_CRC_EN
            if (!r_crcb)
              r_crc_hi <= i_ll_byte;
            else
              o_crc_err <= ({r_crc_hi, i_ll_byte} != r_crc);
`endif
            if (r_crcb) begin
              o_ll_stb <= 1'b0;
              r_state  <= S_DONE;
            end
          end
        end

        S_DONE: begin
          // Let the driver finish its last byte before releasing the bus
          if (!i_ll_busy && !o_ll_stb) begin
            o_busy  <= 1'b0;
            o_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spirxdata.sv
// Randomized self-checking bench for spirxdata: card-side byte model plus a block/CRC reference model.
module tb_spirxdata;
  localparam int DW  = 32;
  localparam int AW  = 8;
  localparam int LGT = 4;

  logic          i_clk = 1'b0;
  logic          i_reset = 1'b1;
  logic          i_start;
  logic [3:0]    i_lgblksz;
  logic          i_fifo;
  logic          o_busy, o_write, o_done, o_err, o_crc_err, o_timeout;
  logic [AW-1:0] o_addr;
  logic [DW-1:0] o_data;
  logic          i_ll_busy, o_ll_stb, i_ll_stb;
  logic [7:0]    o_ll_byte, i_ll_byte;

  spirxdata #(.DW(DW), .AW(AW), .LGTIMEOUT(LGT)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_lgblksz(i_lgblksz),
    .i_fifo(i_fifo), .o_busy(o_busy), .o_write(o_write), .o_addr(o_addr),
    .o_data(o_data), .i_ll_busy(i_ll_busy), .o_ll_stb(o_ll_stb), .o_ll_byte(o_ll_byte),
    .i_ll_stb(i_ll_stb), .i_ll_byte(i_ll_byte), .o_done(o_done), .o_err(o_err),
    .o_crc_err(o_crc_err), .o_timeout(o_timeout)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Card side: each accepted transfer answers after 0..3 busy cycles with the next queued byte
  logic [7:0] card_q[$];
  logic [7:0] data_q[$];
  int  ll_wait = -1;
  int  delivered = 0;
  bit  card_fast = 1'b0;

  initial begin
    i_ll_busy = 1'b0;
    i_ll_stb  = 1'b0;
    i_ll_byte = 8'h00;
    forever begin
      @(negedge i_clk);
      i_ll_stb = 1'b0;
      if (i_reset) begin
        ll_wait   = -1;
        i_ll_busy = 1'b0;
      end else begin
        if (ll_wait == 0) begin
          i_ll_byte = (card_q.size() > 0) ? card_q.pop_front() : 8'hff;
          i_ll_stb  = 1'b1;
          i_ll_busy = 1'b0;
          delivered++;
          ll_wait   = -1;
        end else if (ll_wait > 0) begin
          ll_wait--;
          i_ll_busy = 1'b1;
        end
        if (ll_wait < 0 && o_ll_stb) begin
          ll_wait   = card_fast ? 0 : int'($urandom_range(0, 3));
          i_ll_busy = 1'b0;
        end
      end
    end
  end

  logic [AW-1:0] wr_addr_q[$];
  logic [DW-1:0] wr_data_q[$];
  int   done_cnt = 0;
  logic busy_at_done, err_at_done, crc_at_done, tmo_at_done;

  always @(negedge i_clk) begin
    if (o_write) begin
      wr_addr_q.push_back(o_addr);
      wr_data_q.push_back(o_data);
    end
    if (o_done) begin
      done_cnt++;
      busy_at_done = o_busy;
      err_at_done  = o_err;
      crc_at_done  = o_crc_err;
      tmo_at_done  = o_timeout;
    end
  end

  // CRC16/0x1021 as polynomial long division of the message times x^16
  function automatic logic [15:0] ref_crc();
    logic [16:0] r;
    logic        bitv;
    r = '0;
    for (int i = 0; i < data_q.size() + 2; i++)
      for (int b = 7; b >= 0; b--) begin
        bitv = (i < data_q.size()) ? data_q[i][b] : 1'b0;
        r = {r[15:0], bitv};
        if (r[16]) r = r ^ 17'h11021;
      end
    return r[15:0];
  endfunction

  function automatic int clamp_lg(input logic [3:0] lg);
    return (lg < 4) ? 4 : ((lg > 9) ? 9 : int'(lg));
  endfunction

  task automatic fill_data(input int n, input bit all_ff);
    data_q.delete();
    for (int i = 0; i < n; i++)
      data_q.push_back(all_ff ? 8'hff : 8'($urandom_range(0, 255)));
  endtask

  task automatic load_card(input int nlead, input logic [15:0] flip);
    logic [15:0] c;
    card_q.delete();
    repeat (nlead) card_q.push_back(8'hff);
    card_q.push_back(8'hfe);
    foreach (data_q[i]) card_q.push_back(data_q[i]);
    c = ref_crc() ^ flip;
    card_q.push_back(c[15:8]);
    card_q.push_back(c[7:0]);
  endtask

  task automatic xfer(input logic [3:0] lg, input logic fifo);
    wr_addr_q.delete();
    wr_data_q.delete();
    done_cnt  = 0;
    i_lgblksz = lg;
    i_fifo    = fifo;
    i_start   = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    chk("busy_rise", o_busy, 1);
    chk("stb_rise", o_ll_stb, 1);
    for (int c = 0; c < 6000 && done_cnt == 0; c++) @(negedge i_clk);
    if (done_cnt == 0) chk("done_wait", done_cnt, 1);
    repeat (8) @(negedge i_clk);
  endtask

  task automatic expect_block(input logic [3:0] lg, input logic fifo, input bit bad);
    int nw;
    bit exp_crc;
    nw = (1 << clamp_lg(lg)) / 4;
`ifdef SPIRXDATA_CRC_EN
    exp_crc = bad;
`else
    exp_crc = 1'b0;
`endif
    chk("wr_count", wr_addr_q.size(), nw);
    for (int k = 0; k < nw && k < wr_addr_q.size(); k++) begin
      chk("wr_addr", wr_addr_q[k], {fifo, 7'(k)});
      chk("wr_data", wr_data_q[k],
          {data_q[4*k], data_q[4*k+1], data_q[4*k+2], data_q[4*k+3]});
    end
    chk("done_count", done_cnt, 1);
    chk("busy_at_done", busy_at_done, 0);
    chk("err_at_done", err_at_done, 0);
    chk("tmo_at_done", tmo_at_done, 0);
    chk("crc_err", crc_at_done, exp_crc);
  endtask

  initial begin
    logic [3:0]  lg;
    logic        fifo;
    logic [15:0] flip;
    i_start   = 1'b0;
    i_lgblksz = 4'd0;
    i_fifo    = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("rst_busy", o_busy, 0);
    chk("rst_stb", o_ll_stb, 0);
    chk("rst_write", o_write, 0);
    chk("rst_flags", {o_done, o_err, o_crc_err, o_timeout}, 0);
    chk("rst_addr", o_addr, 0);
    chk("rst_data", o_data, 0);
    i_reset = 1'b0;
    repeat (2) @(negedge i_clk);

    fill_data(512, 1'b1);
    chk("crc_model", ref_crc(), 16'h7fa1);

    // Full 512-byte block of 0xFF
    load_card(3, 16'h0000);
    xfer(4'd9, 1'b0);
    expect_block(4'd9, 1'b0, 1'b0);

    // 16-byte counting pattern to FIFO 1
    data_q.delete();
    for (int i = 0; i < 16; i++) data_q.push_back(8'(i));
    load_card(2, 16'h0000);
    xfer(4'd4, 1'b1);
    expect_block(4'd4, 1'b1, 1'b0);

    // Corrupted CRC low bit
    fill_data(512, 1'b1);
    load_card(3, 16'h0001);
    xfer(4'd9, 1'b0);
    expect_block(4'd9, 1'b0, 1'b1);

    // Data error token
    card_q.delete();
    card_q.push_back(8'hff);
    card_q.push_back(8'h05);
    xfer(4'd9, 1'b0);
    chk("errtok_err", err_at_done, 1);
    chk("errtok_held", o_err, 1);
    chk("errtok_writes", wr_addr_q.size(), 0);
    chk("errtok_done", done_cnt, 1);
    chk("errtok_busy", o_busy, 0);
    chk("errtok_tmo", tmo_at_done, 0);

    // No token at all
    card_q.delete();
    xfer(4'd4, 1'b0);
    chk("tmo_flag", tmo_at_done, 1);
    chk("tmo_held", o_timeout, 1);
    chk("tmo_err", err_at_done, 0);
    chk("tmo_writes", wr_addr_q.size(), 0);
    chk("tmo_done", done_cnt, 1);

    // Token as the last byte before the timeout limit
    fill_data(16, 1'b0);
    load_card((1 << LGT) - 1, 16'h0000);
    xfer(4'd4, 1'b0);
    expect_block(4'd4, 1'b0, 1'b0);

    for (int it = 0; it < 8; it++) begin
      lg        = 4'($urandom_range(0, 15));
      fifo      = 1'($urandom_range(0, 1));
      card_fast = 1'($urandom_range(0, 1));
      flip      = ($urandom_range(0, 1) == 1) ? (16'h0001 << $urandom_range(0, 15)) : 16'h0000;
      fill_data(1 << clamp_lg(lg), 1'b0);
      load_card(int'($urandom_range(0, (1 << LGT) - 2)), flip);
      xfer(lg, fifo);
      expect_block(lg, fifo, flip != 16'h0000);
    end
    card_fast = 1'b0;

    // Reset after six data bytes
    fill_data(512, 1'b0);
    load_card(2, 16'h0000);
    wr_addr_q.delete();
    wr_data_q.delete();
    delivered = 0;
    i_lgblksz = 4'd9;
    i_fifo    = 1'b0;
    i_start   = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(posedge i_clk);
      if (delivered >= 9) break;
    end
    #1;
    chk("rst_mid_bytes", delivered, 9);
    i_reset = 1'b1;
    #1;
    chk("rst_mid_busy", o_busy, 0);
    chk("rst_mid_stb", o_ll_stb, 0);
    chk("rst_mid_write", o_write, 0);
    chk("rst_mid_writes", wr_addr_q.size(), 1);
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;
    repeat (2) @(negedge i_clk);
    chk("rst_mid_nowrite", wr_addr_q.size(), 1);
    fill_data(16, 1'b0);
    load_card(1, 16'h0000);
    xfer(4'd4, 1'b0);
    expect_block(4'd4, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
